hawk_axiwr_arb: RTL

- Round-robin arbiter and sequencer that shares the single write path into hawk_axiwr_master among the write clients: the page-write manager, the ToL updater and the zspage migrator.
- Accepts one full cache-line write (addr/data/strb) from a requester and drives the AW and W valids, tracking each handshake independently.
- Waits for the B response and routes bresp back to the owning requester.
- Only one transaction is in flight at a time.

---
 rtl/hawk_axiwr_arb.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/hawk_axiwr_arb.sv
// Round-robin arbiter that shares the single AXI write path among several clients.
// One full cache-line write is in flight at a time; the B response is routed back to its owner.
module hawk_axiwr_arb #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned STRB_W  = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  input  logic [NUM_REQ*STRB_W-1:0]   req_strb_i,
  output logic [NUM_REQ-1:0]          resp_valid_o,
  output logic [1:0]                  resp_bresp_o,
  output logic [ADDR_W-1:0]           m_addr_o,
  output logic [DATA_W-1:0]           m_data_o,
  output logic [STRB_W-1:0]           m_strb_o,
  output logic                        m_awvalid_o,
  output logic                        m_wvalid_o,
  input  logic                        m_awready_i,
  input  logic                        m_wready_i,
  input  logic                        m_bvalid_i,
  input  logic [1:0]                  m_bresp_i,
  output logic                        busy_o,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id_o,
  output logic                        err_o
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned SUM_W = ID_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_B
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                arm_q, arm_d;
  logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [NUM_REQ-1:0]  ready_c;

  logic [ADDR_W-1:0]   addr_a [NUM_REQ];
  logic [DATA_W-1:0]   data_a [NUM_REQ];
  logic [STRB_W-1:0]   strb_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g] = req_addr_i[g*ADDR_W +: ADDR_W];
    assign data_a[g] = req_data_i[g*DATA_W +: DATA_W];
    assign strb_a[g] = req_strb_i[g*STRB_W +: STRB_W];
  end

  // Round-robin search: first valid requester after the last grant, wrapping modulo NUM_REQ.
  logic              found_c;
  logic [ID_W-1:0]   win_c;
  logic [SUM_W-1:0]  cand_c;

  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    cand_c  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand_c = {1'b0, last_q} + SUM_W'(i);
      if (cand_c >= SUM_W'(NUM_REQ)) begin
        cand_c = cand_c - SUM_W'(NUM_REQ);
      end
      if (!found_c && req_valid_i[cand_c[ID_W-1:0]]) begin
        found_c = 1'b1;
        win_c   = cand_c[ID_W-1:0];
      end
    end
  end

  // Next-state and datapath; a grant is held off while a response pulse is still showing.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    err_d        = err_q;
    arm_d        = 1'b1;
    resp_valid_d = '0;
    bresp_d      = bresp_q;
    addr_d       = addr_q;
    data_d       = data_q;
    strb_d       = strb_q;
    ready_c      = '0;

    case (state_q)
      ST_IDLE: begin
        if (m_bvalid_i) begin
          err_d = 1'b1;
        end
        if (arm_q && (resp_valid_q == '0) && found_c) begin
          ready_c[win_c] = 1'b1;
          addr_d         = addr_a[win_c];
          data_d         = data_a[win_c];
          strb_d         = strb_a[win_c];
          grant_d        = win_c;
          last_d         = win_c;
          state_d        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_bvalid_i) begin
          err_d = 1'b1;
        end
        if (awvalid_q && m_awready_i) begin
          aw_done_d = 1'b1;
        end
        if (wvalid_q && m_wready_i) begin
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (m_bvalid_i) begin
          resp_valid_d[grant_q] = 1'b1;
          bresp_d               = m_bresp_i;
          aw_done_d             = 1'b0;
          w_done_d              = 1'b0;
          state_d               = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    awvalid_d = (state_d == ST_ISSUE) && !aw_done_d;
    wvalid_d  = (state_d == ST_ISSUE) && !w_done_d;
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_q       <= ID_W'(NUM_REQ - 1);
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      arm_q        <= 1'b0;
      resp_valid_q <= '0;
      bresp_q      <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      strb_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      arm_q        <= arm_d;
      resp_valid_q <= resp_valid_d;
      bresp_q      <= bresp_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      strb_q       <= strb_d;
    end
  end

  assign req_ready_o  = ready_c;
  assign resp_valid_o = resp_valid_q;
  assign resp_bresp_o = bresp_q;
  assign m_addr_o     = addr_q;
  assign m_data_o     = data_q;
  assign m_strb_o     = strb_q;
  assign m_awvalid_o  = awvalid_q;
  assign m_wvalid_o   = wvalid_q;
  assign busy_o       = busy_q;
  assign grant_id_o   = grant_q;
  assign err_o        = err_q;

endmodule
